// File: rtl/bsa_pkg.sv
// bsa_pkg: shared types and constants for the bit-serial adder control slice.
// Ports: none. This package holds the sequencer state enum, the datapath width
// and the accept-to-result latency.
package bsa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPTURE
  } bsa_seq_state_t;

  localparam int BSA_WIDTH   = 8;
  // Edges: accept, load, BSA_WIDTH shifts, then capture.
  localparam int BSA_LATENCY = BSA_WIDTH + 2;

endpackage

// File: rtl/bsa_result_reg.sv
// bsa_result_reg: holds the captured adder result until downstream takes it.
// Ports: clk/reset (sync, active-high); capture with sum/carry from the adder;
//        out_valid/out_ready drain handshake with out_sum/out_cout.
//        With BSA_SEQ_OVF_EN defined it also takes the operand MSBs (a_msb,
//        b_msb) and holds the signed overflow flag out_ovf.
module bsa_result_reg
  import bsa_pkg::*;
#(
  parameter int WIDTH = BSA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
`ifdef BSA_SEQ_OVF_EN
  input  logic             a_msb,
  input  logic             b_msb,
  output logic             out_ovf,
`endif
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else if (capture) begin
      // Capture never coincides with a held result: the sequencer only
      // accepts a new pair once the previous one has drained.
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_cout  <= carry;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BSA_SEQ_OVF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_ovf <= 1'b0;
    end else if (capture) begin
      // Like-signed operands whose sum flips sign.
      out_ovf <= (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
    end
  end
`endif

endmodule

// File: rtl/bsa_sequencer.sv
// bsa_sequencer: drives the bit-serial adder (load, WIDTH shifts) and captures its result.
// Ports: in_valid/in_ready/in_a/in_b operand handshake; add_a/add_b/add_mode/add_reset
//        to the adder, add_sum/add_carry back from it; out_valid/out_ready/out_sum/out_cout
//        result handshake. BSA_SEQ_OVF_EN adds out_ovf (signed overflow of the result).
module bsa_sequencer
  import bsa_pkg::*;
#(
  parameter int WIDTH = BSA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_mode,
  output logic             add_reset,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef BSA_SEQ_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  bsa_seq_state_t state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      add_a <= '0;
      add_b <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        add_a <= in_a;
        add_b <= in_b;
      end
      if (state == LOAD) begin
        cnt <= '0;
      end else if (state == SHIFT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    add_mode  = 1'b0;
    // Reset also clears the adder on the same edge, so an aborted
    // operation leaves nothing behind in the shift registers or carry.
    add_reset = reset;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        add_reset = 1'b1;
        // Gated by the held result so a stalled output is never overwritten.
        in_ready  = !out_valid;
        if (in_valid && !out_valid) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        add_mode  = !reset;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == CNT_LAST) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        // The adder keeps shifting, so capture cannot wait for downstream.
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  bsa_result_reg #(.WIDTH(WIDTH)) u_result (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .sum       (add_sum),
    .carry     (add_carry),
`ifdef BSA_SEQ_OVF_EN
    .a_msb     (add_a[WIDTH-1]),
    .b_msb     (add_b[WIDTH-1]),
    .out_ovf   (out_ovf),
`endif
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

endmodule

// File: tb/tb_bsa_sequencer.sv
module tb_bsa_sequencer;
  import bsa_pkg::*;

  localparam int W = BSA_WIDTH;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] add_a, add_b;
  logic         add_mode, add_reset;
  logic [W-1:0] add_sum;
  logic         add_carry;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef BSA_SEQ_OVF_EN
  logic         out_ovf;
`endif

  bsa_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_mode  (add_mode),
    .add_reset (add_reset),
    .add_sum   (add_sum),
    .add_carry (add_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
`ifdef BSA_SEQ_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .out_cout  (out_cout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // External bit-serial adder: LSB-first, sum shifts in from the top.
  logic [W-1:0] ad_a, ad_b, ad_s;
  logic         ad_c;
  always @(posedge clk) begin
    if (add_reset) begin
      ad_a <= '0; ad_b <= '0; ad_s <= '0; ad_c <= 1'b0;
    end else if (add_mode) begin
      ad_a <= add_a; ad_b <= add_b;
    end else begin
      ad_a <= ad_a >> 1;
      ad_b <= ad_b >> 1;
      ad_s <= {ad_a[0] ^ ad_b[0] ^ ad_c, ad_s[W-1:1]};
      ad_c <= (ad_a[0] & ad_b[0]) | (ad_c & (ad_a[0] ^ ad_b[0]));
    end
  end
  assign add_sum   = ad_s;
  assign add_carry = ad_c;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: pending operand pairs with their accept cycle.
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           t;
  } op_t;
  op_t q[$];
  int  n_res      = 0;
  int  exp_res    = 0;
  int  last_rise  = -1;
  bit  chk_period = 1'b0;
  bit  prev_ov    = 1'b0;

  always @(negedge clk) begin
    op_t          op;
    logic [W:0]   full;
    if (reset) begin
      q.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        check("valid_has_op", q.size() > 0, 1);
        if (q.size() > 0) check("latency", cyc - q[0].t, BSA_LATENCY);
        // Accept, BSA_LATENCY edges, one drain edge, then the next accept.
        if (chk_period && last_rise >= 0) check("issue_interval", cyc - last_rise, BSA_LATENCY + 2);
        last_rise = cyc;
      end
      if (out_valid && out_ready && q.size() > 0) begin
        op   = q.pop_front();
        full = {1'b0, op.a} + {1'b0, op.b};
        check("sum", out_sum, full[W-1:0]);
        check("cout", out_cout, full[W]);
`ifdef BSA_SEQ_OVF_EN
        check("ovf", out_ovf, (op.a[W-1] == op.b[W-1]) && (full[W-1] != op.a[W-1]));
`endif
        n_res++;
      end
      if (in_valid && in_ready) q.push_back('{a: in_a, b: in_b, t: cyc + 1});
      prev_ov = out_valid;
    end
  end

  bit rand_bp = 1'b0;
  always @(posedge clk) begin
    if (rand_bp) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Offer a pair and hold it until the accept edge has passed.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int i;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("accept_in_time", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_res++;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    check("drained", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int i;
    bit seen;
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    bit seen;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_mode", add_mode, 0);
    check("rst_add_reset", add_reset, 1);
    check("rst_in_ready", in_ready, 1);
`ifdef BSA_SEQ_OVF_EN
    check("rst_out_ovf", out_ovf, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic add with free-running output.
    send(8'h35, 8'h4A);
    wait_idle();
    check("t1_sum", out_sum, 8'h7F);
    check("t1_cout", out_cout, 0);

    // Carry out, then a zero add to show the carry does not leak.
    send(8'hFF, 8'h01);
    wait_idle();
    check("t2_sum", out_sum, 8'h00);
    check("t2_cout", out_cout, 1);
    send(8'h00, 8'h00);
    wait_idle();
    check("t3_sum", out_sum, 8'h00);
    check("t3_cout", out_cout, 0);

    // Stalled output: result held, next pair waits until one cycle after drain.
    out_ready = 1'b0;
    send(8'h10, 8'h20);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    @(posedge clk); #1;
    in_a = 8'h11; in_b = 8'h22; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_sum", out_sum, 8'h30);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_cycle_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_drain_valid", out_valid, 0);
    check("after_drain_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_res++;
    wait_idle();
    check("t4_sum", out_sum, 8'h33);

    // Reset during the 4th shift cycle aborts the operation.
    send(8'hAA, 8'h55);
    exp_res--;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    check("abort_dp_clear", add_reset, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_add_reset", add_reset, 1);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); seen |= out_valid; end
    check("abort_no_valid", seen, 0);
    @(posedge clk); #1;
    send(8'h01, 8'h02);
    wait_idle();
    check("t5_sum", out_sum, 8'h03);

    // Continuous offers with out_ready high: fixed issue interval, in order.
    last_rise  = -1;
    chk_period = 1'b1;
    for (int k = 0; k < 6; k++) send(W'($urandom), W'($urandom));
    wait_idle();
    chk_period = 1'b0;

`ifdef BSA_SEQ_OVF_EN
    send(8'h7F, 8'h01);
    wait_idle();
    check("ovf_pos", out_ovf, 1);
    check("ovf_pos_cout", out_cout, 0);
    send(8'h80, 8'h80);
    wait_idle();
    check("ovf_neg", out_ovf, 1);
    check("ovf_neg_cout", out_cout, 1);
    check("ovf_neg_sum", out_sum, 8'h00);
`endif

    // Random operands, random gaps, random downstream backpressure.
    rand_bp = 1'b1;
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send(W'($urandom), W'($urandom));
    end
    wait_idle();
    rand_bp = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_idle();

    check("result_count", n_res, exp_res);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
